// File: rtl/mmio_bridge.sv
// CPU-side MMIO initiator: decodes one load/store at a time against the
// peripheral map, drives the shared write port and returns a one-cycle ack.
module mmio_bridge #(
    parameter int unsigned TIM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    output logic        o_cpu_ack,
    output logic        o_cpu_err,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_stall,
    output logic        o_per_wen,
    output logic [31:0] o_per_addr,
    output logic [31:0] o_per_wdata,
    input  logic [31:0] i_tim_rdata,
    input  logic [31:0] i_sw_rdata,
    input  logic [31:0] i_btn_rdata
);

    localparam logic [31:0] ADDR_DIG = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_TIM = 32'hFFFF_F020;
    localparam logic [31:0] ADDR_FRE = 32'hFFFF_F024;
    localparam logic [31:0] ADDR_LED = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW  = 32'hFFFF_F070;
    localparam logic [31:0] ADDR_BTN = 32'hFFFF_F078;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_RWAIT = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] LAT = 3'(TIM_LAT);

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_led;
    logic [31:0] r_dig;
    logic        r_err;

    logic        w_dig, w_tim, w_fre, w_led, w_sw, w_btn;
    logic        w_st_ok, w_ld_ok, w_ld_tim;
    logic [31:0] w_ld_data;

    assign w_dig = (i_cpu_addr == ADDR_DIG);
    assign w_tim = (i_cpu_addr == ADDR_TIM);
    assign w_fre = (i_cpu_addr == ADDR_FRE);
    assign w_led = (i_cpu_addr == ADDR_LED);
    assign w_sw  = (i_cpu_addr == ADDR_SW);
    assign w_btn = (i_cpu_addr == ADDR_BTN);

    assign w_st_ok  = i_cpu_we & (w_dig | w_tim | w_fre | w_led);
    assign w_ld_tim = ~i_cpu_we & w_tim;
    assign w_ld_ok  = ~i_cpu_we & (w_sw | w_btn | w_dig | w_led);

    // Immediate-load sources; illegal accesses fall through to zero
    always_comb begin
        w_ld_data = '0;
        if (w_ld_ok) begin
            w_ld_data = ({32{w_sw}}  & i_sw_rdata)
                      | ({32{w_btn}} & i_btn_rdata)
                      | ({32{w_dig}} & r_dig)
                      | ({32{w_led}} & r_led);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_led   <= '0;
            r_dig   <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_cpu_req) begin
                        r_addr  <= i_cpu_addr;
                        r_wdata <= i_cpu_wdata;
                        if (w_st_ok) begin
                            r_state <= S_WRITE;
                        end else if (w_ld_tim) begin
                            r_cnt   <= LAT;
                            r_state <= S_RWAIT;
                        end else begin
                            r_rdata <= w_ld_data;
                            r_err   <= ~w_ld_ok;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_WRITE: begin
                    if (r_addr == ADDR_LED) r_led <= r_wdata;
                    if (r_addr == ADDR_DIG) r_dig <= r_wdata;
                    r_err   <= 1'b0;
                    r_state <= S_RESP;
                end
                S_RWAIT: begin
                    if (r_cnt == 3'd1) begin
                        r_rdata <= i_tim_rdata;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cpu_ack   = (r_state == S_RESP);
    assign o_cpu_err   = r_err;
    assign o_cpu_rdata = r_rdata;
    assign o_cpu_stall = i_cpu_req & ~o_cpu_ack;
    assign o_per_wen   = (r_state == S_WRITE);
    assign o_per_addr  = r_addr;
    assign o_per_wdata = r_wdata;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: two instances (timer latency 1 and 3)
// share all inputs except the request strobe.
module tb_mmio_bridge;

    localparam logic [31:0] ADDR_DIG = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_TIM = 32'hFFFF_F020;
    localparam logic [31:0] ADDR_FRE = 32'hFFFF_F024;
    localparam logic [31:0] ADDR_LED = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW  = 32'hFFFF_F070;
    localparam logic [31:0] ADDR_BTN = 32'hFFFF_F078;

    logic        clk = 1'b0;
    logic        rst;
    logic        req1, req3;
    logic        we;
    logic [31:0] addr, wdata;
    logic [31:0] tim_rdata, sw_rdata, btn_rdata;

    logic        ack1, err1, stall1, wen1;
    logic [31:0] rdata1, paddr1, pwdata1;
    logic        ack3, err3, stall3, wen3;
    logic [31:0] rdata3, paddr3, pwdata3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mmio_bridge #(.TIM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_cpu_req(req1), .i_cpu_we(we),
        .i_cpu_addr(addr), .i_cpu_wdata(wdata),
        .o_cpu_ack(ack1), .o_cpu_err(err1),
        .o_cpu_rdata(rdata1), .o_cpu_stall(stall1),
        .o_per_wen(wen1), .o_per_addr(paddr1),
        .o_per_wdata(pwdata1),
        .i_tim_rdata(tim_rdata), .i_sw_rdata(sw_rdata),
        .i_btn_rdata(btn_rdata)
    );

    mmio_bridge #(.TIM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .i_cpu_req(req3), .i_cpu_we(we),
        .i_cpu_addr(addr), .i_cpu_wdata(wdata),
        .o_cpu_ack(ack3), .o_cpu_err(err3),
        .o_cpu_rdata(rdata3), .o_cpu_stall(stall3),
        .o_per_wen(wen3), .o_per_addr(paddr3),
        .o_per_wdata(pwdata3),
        .i_tim_rdata(tim_rdata), .i_sw_rdata(sw_rdata),
        .i_btn_rdata(btn_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction; timer data is valid only during cycle tim_at
    task automatic xact(
        input  bit          sel,
        input  logic        w,
        input  logic [31:0] a,
        input  logic [31:0] d,
        input  int          tim_at,
        output int          ack_cyc,
        output int          wen_cnt,
        output int          wen_cyc,
        output int          stall_cnt,
        output logic [31:0] wa,
        output logic [31:0] wd,
        output logic [31:0] rd,
        output logic        er
    );
        logic a_ack, a_wen, a_stall;
        ack_cyc = -1; wen_cnt = 0; wen_cyc = -1; stall_cnt = 0;
        wa = '0; wd = '0; rd = '0; er = 1'b0;
        @(negedge clk);
        we = w; addr = a; wdata = d;
        tim_rdata = (tim_at == 0) ? 32'h1234 : 32'hDEAD_0000;
        if (sel) req3 = 1'b1; else req1 = 1'b1;
        #1;
        a_stall = sel ? stall3 : stall1;
        if (a_stall) stall_cnt++;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            tim_rdata = (k == tim_at) ? 32'h1234 : (32'hDEAD_0000 + k);
            a_ack   = sel ? ack3 : ack1;
            a_wen   = sel ? wen3 : wen1;
            a_stall = sel ? stall3 : stall1;
            if (a_stall) stall_cnt++;
            if (a_wen) begin
                wen_cnt++;
                wen_cyc = k;
                wa = sel ? paddr3 : paddr1;
                wd = sel ? pwdata3 : pwdata1;
            end
            if (a_ack) begin
                ack_cyc = k;
                rd = sel ? rdata3 : rdata1;
                er = sel ? err3 : err1;
                break;
            end
        end
        req1 = 1'b0; req3 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            a_wen = sel ? wen3 : wen1;
            if (a_wen) wen_cnt++;
        end
    endtask

    int          ac, wc, wy, sc;
    logic [31:0] wa, wd, rd;
    logic        er;

    initial begin
        rst = 1'b1; req1 = 1'b0; req3 = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; tim_rdata = '0;
        sw_rdata = 32'h0000_8001; btn_rdata = 32'h0000_0003;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",   {31'b0, ack1}, 32'h0);
        chk("rst_wen",   {31'b0, wen1}, 32'h0);
        chk("rst_err",   {31'b0, err1}, 32'h0);
        chk("rst_addr",  paddr1, 32'h0);
        chk("rst_wdata", pwdata1, 32'h0);
        chk("rst_rdata", rdata1, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        xact(0, 1'b1, ADDR_FRE, 32'h0000_00FF, 99,
             ac, wc, wy, sc, wa, wd, rd, er);
        chk("fre_ack_cyc", ac, 2);
        chk("fre_wen_cnt", wc, 1);
        chk("fre_wen_cyc", wy, 1);
        chk("fre_addr",    wa, ADDR_FRE);
        chk("fre_data",    wd, 32'h0000_00FF);
        chk("fre_err",     {31'b0, er}, 32'h0);
        chk("fre_stall",   sc, 2);

        xact(0, 1'b1, ADDR_TIM, 32'h10, 99,
             ac, wc, wy, sc, wa, wd, rd, er);
        chk("tim_st_ack_cyc", ac, 2);
        chk("tim_st_wen_cnt", wc, 1);
        chk("tim_st_addr",    wa, ADDR_TIM);
        chk("tim_st_data",    wd, 32'h10);
        chk("tim_st_err",     {31'b0, er}, 32'h0);

        xact(0, 1'b0, ADDR_TIM, 32'h0, 1,
             ac, wc, wy, sc, wa, wd, rd, er);
        chk("tim1_ack_cyc", ac, 2);
        chk("tim1_rdata",   rd, 32'h1234);
        chk("tim1_wen_cnt", wc, 0);
        chk("tim1_err",     {31'b0, er}, 32'h0);

        xact(1, 1'b0, ADDR_TIM, 32'h0, 3,
             ac, wc, wy, sc, wa, wd, rd, er);
        chk("tim3_ack_cyc", ac, 4);
        chk("tim3_rdata",   rd, 32'h1234);
        chk("tim3_stall",   sc, 4);

        xact(0, 1'b1, ADDR_LED, 32'hA5, 99,
             ac, wc, wy, sc, wa, wd, rd, er);
        chk("led_st_ack_cyc", ac, 2);
        chk("led_st_wen_cnt", wc, 1);
        xact(0, 1'b0, ADDR_LED, 32'h0, 99,
             ac, wc, wy, sc, wa, wd, rd, er);
        chk("led_ld_ack_cyc", ac, 1);
        chk("led_ld_rdata",   rd, 32'hA5);
        chk("led_ld_wen_cnt", wc, 0);
        chk("led_ld_err",     {31'b0, er}, 32'h0);
        chk("led_rdata_hold", rdata1, 32'hA5);

        xact(0, 1'b0, ADDR_DIG, 32'h0, 99,
             ac, wc, wy, sc, wa, wd, rd, er);
        chk("dig_ld_rdata", rd, 32'h0);
        chk("dig_ld_err",   {31'b0, er}, 32'h0);

        xact(0, 1'b0, ADDR_SW, 32'h0, 99,
             ac, wc, wy, sc, wa, wd, rd, er);
        chk("sw_ack_cyc", ac, 1);
        chk("sw_rdata",   rd, 32'h0000_8001);
        chk("sw_err",     {31'b0, er}, 32'h0);

        xact(0, 1'b0, ADDR_BTN, 32'h0, 99,
             ac, wc, wy, sc, wa, wd, rd, er);
        chk("btn_rdata", rd, 32'h0000_0003);

        xact(0, 1'b1, ADDR_BTN, 32'h77, 99,
             ac, wc, wy, sc, wa, wd, rd, er);
        chk("btn_st_ack_cyc", ac, 1);
        chk("btn_st_err",     {31'b0, er}, 32'h1);
        chk("btn_st_wen_cnt", wc, 0);

        xact(0, 1'b0, 32'hFFFF_F100, 32'h0, 99,
             ac, wc, wy, sc, wa, wd, rd, er);
        chk("unmap_ack_cyc", ac, 1);
        chk("unmap_err",     {31'b0, er}, 32'h1);
        chk("unmap_rdata",   rd, 32'h0);

        xact(0, 1'b0, ADDR_FRE, 32'h0, 99,
             ac, wc, wy, sc, wa, wd, rd, er);
        chk("fre_ld_ack_cyc", ac, 1);
        chk("fre_ld_err",     {31'b0, er}, 32'h1);
        chk("fre_ld_rdata",   rd, 32'h0);

        // Abort a latency-3 timer load mid-wait
        @(negedge clk);
        we = 1'b0; addr = ADDR_TIM; wdata = 32'h0; req3 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_pre_ack", {31'b0, ack3}, 32'h0);
        rst = 1'b1;
        #1;
        chk("abort_ack",   {31'b0, ack3}, 32'h0);
        chk("abort_addr",  paddr3, 32'h0);
        chk("abort_rdata", rdata3, 32'h0);
        chk("abort_err",   {31'b0, err3}, 32'h0);
        chk("abort_wen",   {31'b0, wen3}, 32'h0);
        req3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wc = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ack3 || wen3) wc++;
        end
        chk("abort_quiet", wc, 0);

        xact(1, 1'b1, ADDR_DIG, 32'hCAFE_0001, 99,
             ac, wc, wy, sc, wa, wd, rd, er);
        chk("post_rst_ack_cyc", ac, 2);
        chk("post_rst_wen_cnt", wc, 1);
        chk("post_rst_addr",    wa, ADDR_DIG);
        chk("post_rst_data",    wd, 32'hCAFE_0001);
        xact(1, 1'b0, ADDR_DIG, 32'h0, 99,
             ac, wc, wy, sc, wa, wd, rd, er);
        chk("dig_shadow", rd, 32'hCAFE_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
